branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
// - Controller that sequences branch resolution in EX and PC redirection in IF.
// - Evaluates the B-type condition and computes the target index.
// - Issues one redirect request to fetch with a valid/ready handshake.
// - Stalls EX and flushes the wrong-path front-end stages until the redirect completes.
// - Keeps branch and taken statistics counters for the debug port.
// PARAMETERS
// - XLEN         32  datapath width
// - IDX_SHIFT    1   right shift from byte target to fetch index (target_idx = (pc+imm)>>IDX_SHIFT)
// - FLUSH_DEPTH  2   cycles of flush after the redirect is accepted (>=1)
// - CNT_W        16  statistics counter width
// PORTS
// - clk             in   1      clock, rising edge
// - reset           in   1      reset, synchronous, active-high
// - br_valid        in   1      EX holds a B-type instruction this cycle
// - funct3          in   3      branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
// - rs1, rs2        in   XLEN   operand values, already forwarded
// - ex_pc           in   XLEN   byte PC of the branch
// - ex_imm          in   XLEN   sign-extended byte offset
// - fetch_ready     in   1      fetch accepts redirect this cycle
// - redirect_valid  out  1      redirect request to fetch
// - redirect_idx    out  XLEN   target fetch index, stable while redirect_valid=1
// - ex_hold         out  1      stall EX/ID/IF pipeline registers
// - flush_front     out  1      squash IF/ID contents (wrong path)
// - illegal_br      out  1      one-cycle pulse: funct3 010/011 seen
// - branch_cnt      out  CNT_W  branches evaluated, saturating
// - taken_cnt       out  CNT_W  branches taken, saturating
// BEHAVIOUR
// - All outputs registered.
// - Reset values:
//   - state IDLE; redirect_valid, ex_hold, flush_front, illegal_br = 0
//   - redirect_idx = 1
//   - counters = 0
// - FSM states: IDLE, REQ, FLUSH.
// - IDLE, br_valid=1:
//   - branch_cnt += 1.
//   - If the condition is true: latch target_idx, taken_cnt += 1, go to REQ.
//   - Result: redirect_valid, ex_hold and flush_front are all 1 the cycle after the branch is in EX.
//   - If the condition is false: stay in IDLE, no output change.
// - REQ:
//   - redirect_valid=1, ex_hold=1, flush_front=1; redirect_idx held constant.
//   - On fetch_ready=1 the transfer happens this cycle.
//   - Next cycle: state FLUSH, redirect_valid=0, ex_hold=0, flush counter = FLUSH_DEPTH-1.
// - FLUSH:
//   - flush_front=1 for exactly FLUSH_DEPTH cycles, then return to IDLE.
// - br_valid in REQ or FLUSH is wrong-path: ignored and not counted.
// - Condition and arithmetic:
//   - BLT/BGE compare signed; BLTU/BGEU compare unsigned.
//   - Target = ex_pc + ex_imm, modulo 2^XLEN (wraps, no overflow flag), then >> IDX_SHIFT (logical).
// - funct3 010 or 011:
//   - Treated as not-taken, counted in branch_cnt.
//   - illegal_br=1 for one cycle, aligned with the cycle a taken branch would enter REQ.
// - Counters saturate at all-ones.
//   - taken_cnt saturating does not block the redirect.
// - reset=1 in any state: next cycle everything is at reset values.
//   - Any pending redirect is dropped; no partial flush.
// - fetch_ready is ignored outside REQ.
// - Back-to-back taken branches: the second is always wrong-path, so it is discarded.
// STRUCTURE
// - Shared package: funct3 branch encodings, FSM state encoding, RESET_IDX=1.
// - Sub-module branch_cond_eval: combinational (funct3, rs1, rs2) -> taken, illegal.
// - Top holds the FSM, flush counter, target register and statistics counters.
// TESTING
// - BEQ rs1=rs2=5, pc=0x100, imm=0x20, fetch_ready=1
//   -> redirect_valid 1 cycle, redirect_idx=0x90, flush_front 1+2 cycles, taken_cnt=1.
// - BNE rs1=rs2 -> no redirect; branch_cnt=1, taken_cnt=0, ex_hold stays 0.
// - BLT rs1=0xFFFFFFFF, rs2=1 -> taken; same operands with BLTU -> not taken.
// - Taken branch, fetch_ready low 3 cycles
//   -> redirect_valid/ex_hold held 4 cycles, redirect_idx stable; br_valid in REQ not counted.
// - pc=0xFFFFFFF0, imm=0x20 -> redirect_idx=0x8 (wrap); funct3=010 -> illegal_br pulse, no redirect.
// - reset asserted in REQ -> next cycle all outputs at reset values (redirect_idx=1), counters=0.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: funct3 branch encodings,
// FSM state encoding and the reset value of the redirect index.
package branch_redirect_ctrl_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } br_state_e;

  localparam int unsigned RESET_IDX = 1;

  // 010 and 011 are the only unused encodings in the B-type funct3 space.
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake between the branch controller (master) and fetch (slave).
interface branch_redirect_ctrl_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_idx;
  logic            fetch_ready;

  modport master (
    output redirect_valid,
    output redirect_idx,
    input  fetch_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_idx,
    output fetch_ready
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational B-type condition evaluation: funct3 and operands in, taken and
// illegal-encoding flags out.
module branch_cond_eval
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  assign rs1_s = rs1_i;
  assign rs2_s = rs2_i;
  assign eq    = (rs1_i == rs2_i);
  assign lt_s  = (rs1_s < rs2_s);
  assign lt_u  = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = is_illegal_f3(funct3_i);
    case (br_funct3_e'(funct3_i))
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = ~eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = ~lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = ~lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution / PC redirect sequencer: resolves B-type branches in EX,
// issues one redirect to fetch, stalls EX and flushes the wrong-path front end.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IDX_SHIFT   = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           br_valid,
  input  logic [2:0]                     funct3,
  input  logic [XLEN-1:0]                rs1,
  input  logic [XLEN-1:0]                rs2,
  input  logic [XLEN-1:0]                ex_pc,
  input  logic [XLEN-1:0]                ex_imm,
  branch_redirect_ctrl_if.master         rd,
  output logic                           ex_hold,
  output logic                           flush_front,
  output logic                           illegal_br,
  output logic [CNT_W-1:0]               branch_cnt,
  output logic [CNT_W-1:0]               taken_cnt
);

  localparam int FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  br_state_e        state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0]  idx_q, idx_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic             ex_hold_q, ex_hold_d;
  logic             flush_front_q, flush_front_d;
  logic             illegal_br_q, illegal_br_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             cond_taken;
  logic             cond_illegal;
  logic [XLEN-1:0]  target_byte;
  logic [XLEN-1:0]  target_idx;

  branch_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .funct3_i  (funct3),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  // Byte target wraps modulo 2^XLEN before the logical shift to a fetch index.
  assign target_byte = ex_pc + ex_imm;
  assign target_idx  = target_byte >> IDX_SHIFT;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    idx_d            = idx_q;
    redirect_valid_d = redirect_valid_q;
    ex_hold_d        = ex_hold_q;
    flush_front_d    = flush_front_q;
    illegal_br_d     = 1'b0;
    branch_cnt_d     = branch_cnt_q;
    taken_cnt_d      = taken_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          branch_cnt_d = sat_inc(branch_cnt_q);
          illegal_br_d = cond_illegal;
          if (cond_taken) begin
            idx_d            = target_idx;
            taken_cnt_d      = sat_inc(taken_cnt_q);
            state_d          = ST_REQ;
            redirect_valid_d = 1'b1;
            ex_hold_d        = 1'b1;
            flush_front_d    = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (rd.fetch_ready) begin
          state_d          = ST_FLUSH;
          redirect_valid_d = 1'b0;
          ex_hold_d        = 1'b0;
          flush_front_d    = 1'b1;
          flush_cnt_d      = FC_W'(FLUSH_DEPTH - 1);
        end
      end
      ST_FLUSH: begin
        // flush_front is already high for this cycle; drop it after the last one.
        if (flush_cnt_q == '0) begin
          state_d       = ST_IDLE;
          flush_front_d = 1'b0;
        end else begin
          flush_cnt_d   = flush_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        redirect_valid_d = 1'b0;
        ex_hold_d        = 1'b0;
        flush_front_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= '0;
      idx_q            <= XLEN'(RESET_IDX);
      redirect_valid_q <= 1'b0;
      ex_hold_q        <= 1'b0;
      flush_front_q    <= 1'b0;
      illegal_br_q     <= 1'b0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      idx_q            <= idx_d;
      redirect_valid_q <= redirect_valid_d;
      ex_hold_q        <= ex_hold_d;
      flush_front_q    <= flush_front_d;
      illegal_br_q     <= illegal_br_d;
      branch_cnt_q     <= branch_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign rd.redirect_valid = redirect_valid_q;
  assign rd.redirect_idx   = idx_q;
  assign ex_hold           = ex_hold_q;
  assign flush_front       = flush_front_q;
  assign illegal_br        = illegal_br_q;
  assign branch_cnt        = branch_cnt_q;
  assign taken_cnt         = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             br_valid;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic             ex_hold;
  logic             flush_front;
  logic             illegal_br;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int n_chk;
  int n_fail;

  branch_redirect_ctrl_if #(.XLEN(XLEN)) bif ();

  branch_redirect_ctrl #(
    .XLEN        (XLEN),
    .IDX_SHIFT   (1),
    .FLUSH_DEPTH (2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .br_valid    (br_valid),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .rd          (bif),
    .ex_hold     (ex_hold),
    .flush_front (flush_front),
    .illegal_br  (illegal_br),
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Present one branch to EX for a single cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    funct3   = f3;
    rs1      = a;
    rs2      = b;
    ex_pc    = pc;
    ex_imm   = imm;
    br_valid = 1'b1;
    step();
    br_valid = 1'b0;
  endtask

  // Accept the pending redirect and drain the two flush cycles.
  task automatic drain();
    bif.fetch_ready = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic h, input logic f);
    chk({tag, ".valid"}, 32'(bif.redirect_valid), 32'(v));
    chk({tag, ".hold"},  32'(ex_hold),            32'(h));
    chk({tag, ".flush"}, 32'(flush_front),        32'(f));
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    reset           = 1'b1;
    br_valid        = 1'b0;
    funct3          = 3'b000;
    rs1             = '0;
    rs2             = '0;
    ex_pc           = '0;
    ex_imm          = '0;
    bif.fetch_ready = 1'b0;
    step();
    step();

    chk_outs("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.idx",     bif.redirect_idx, 32'h1);
    chk("rst.illegal", 32'(illegal_br),  32'h0);
    chk("rst.bcnt",    32'(branch_cnt),  32'h0);
    chk("rst.tcnt",    32'(taken_cnt),   32'h0);
    reset = 1'b0;

    // BEQ taken, fetch ready immediately
    bif.fetch_ready = 1'b1;
    issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    chk_outs("beq.req", 1'b1, 1'b1, 1'b1);
    chk("beq.idx",  bif.redirect_idx, 32'h90);
    chk("beq.tcnt", 32'(taken_cnt),   32'h1);
    chk("beq.bcnt", 32'(branch_cnt),  32'h1);
    step();
    chk_outs("beq.fl1", 1'b0, 1'b0, 1'b1);
    step();
    chk_outs("beq.fl2", 1'b0, 1'b0, 1'b1);
    step();
    chk_outs("beq.idle", 1'b0, 1'b0, 1'b0);

    // BNE with equal operands: not taken
    do_reset();
    issue(3'b001, 32'd9, 32'd9, 32'h100, 32'h20);
    chk_outs("bne", 1'b0, 1'b0, 1'b0);
    chk("bne.bcnt", 32'(branch_cnt), 32'h1);
    chk("bne.tcnt", 32'(taken_cnt),  32'h0);

    // BLT signed taken, BLTU unsigned not taken
    do_reset();
    bif.fetch_ready = 1'b0;
    issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h40);
    chk("blt.valid", 32'(bif.redirect_valid), 32'h1);
    chk("blt.idx",   bif.redirect_idx,        32'h20);
    drain();
    issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h40);
    chk("bltu.valid", 32'(bif.redirect_valid), 32'h0);
    chk("bltu.bcnt",  32'(branch_cnt),         32'h2);
    chk("bltu.tcnt",  32'(taken_cnt),          32'h1);

    // BGE taken with fetch stalled 3 cycles; wrong-path br_valid in REQ/FLUSH
    do_reset();
    bif.fetch_ready = 1'b0;
    issue(3'b101, 32'd7, 32'd3, 32'h200, 32'hFFFF_FFF8);
    funct3   = 3'b000;
    rs1      = 32'd1;
    rs2      = 32'd1;
    ex_pc    = 32'h400;
    ex_imm   = 32'h0;
    br_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_outs($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b1);
      chk($sformatf("stall%0d.idx", i), bif.redirect_idx, 32'hFC);
      step();
    end
    chk_outs("stall3", 1'b1, 1'b1, 1'b1);
    chk("stall3.idx", bif.redirect_idx, 32'hFC);
    bif.fetch_ready = 1'b1;
    step();
    chk_outs("stall.fl1", 1'b0, 1'b0, 1'b1);
    step();
    br_valid = 1'b0;
    chk_outs("stall.fl2", 1'b0, 1'b0, 1'b1);
    step();
    chk_outs("stall.idle", 1'b0, 1'b0, 1'b0);
    chk("stall.bcnt", 32'(branch_cnt), 32'h1);
    chk("stall.tcnt", 32'(taken_cnt),  32'h1);

    // Target wrap, then illegal funct3
    do_reset();
    bif.fetch_ready = 1'b1;
    issue(3'b000, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20);
    chk("wrap.idx", bif.redirect_idx, 32'h8);
    drain();
    issue(3'b010, 32'd0, 32'd0, 32'h100, 32'h20);
    chk("ill.pulse", 32'(illegal_br),         32'h1);
    chk("ill.valid", 32'(bif.redirect_valid), 32'h0);
    chk("ill.bcnt",  32'(branch_cnt),         32'h2);
    chk("ill.tcnt",  32'(taken_cnt),          32'h1);
    step();
    chk("ill.clear", 32'(illegal_br), 32'h0);

    // Reset while in REQ
    do_reset();
    bif.fetch_ready = 1'b0;
    issue(3'b111, 32'd8, 32'd2, 32'h300, 32'h10);
    chk("rreq.valid", 32'(bif.redirect_valid), 32'h1);
    chk("rreq.idx",   bif.redirect_idx,        32'h188);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_outs("rreq.after", 1'b0, 1'b0, 1'b0);
    chk("rreq.idx0", bif.redirect_idx, 32'h1);
    chk("rreq.bcnt", 32'(branch_cnt),  32'h0);
    chk("rreq.tcnt", 32'(taken_cnt),   32'h0);
    step();
    chk_outs("rreq.stay", 1'b0, 1'b0, 1'b0);

    // Counter saturation at 3'b111; a taken branch still redirects when saturated
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bif.fetch_ready = 1'b0;
      issue(3'b000, 32'd4, 32'd4, 32'h0, 32'(i * 4));
      if (i == 8) begin
        chk("sat.valid", 32'(bif.redirect_valid), 32'h1);
        chk("sat.idx",   bif.redirect_idx,        32'h10);
      end
      drain();
    end
    chk("sat.bcnt", 32'(branch_cnt), 32'h7);
    chk("sat.tcnt", 32'(taken_cnt),  32'h7);
    issue(3'b001, 32'd4, 32'd4, 32'h0, 32'h0);
    chk("sat.bcnt2", 32'(branch_cnt), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
